// File: rtl/sdmac_fifo_ctrl.sv
// sdmac_fifo_ctrl: bookkeeping for the 8-longword DMA FIFO.
// Tracks longword occupancy, the next-in/next-out longword pointers and the
// 2-bit byte-offset pointer. Flags are registered from the next-count so they
// move on the same edge as FIFO_CNT.
// Optional build macro FIFO_ERR_EN adds sticky OVF/UNF error outputs.
module sdmac_fifo_ctrl #(
    parameter int PTR_W = 3
) (
    input  logic             CPUCLK,
    input  logic             RESET,
    input  logic             FIFO_CLR,
    input  logic             INCFIFO,
    input  logic             DECFIFO,
    input  logic             INCNI,
    input  logic             INCNO,
    input  logic             INCBO,
    input  logic             BO_LD,
    input  logic [1:0]       BO_D,
    output logic             FIFOFULL,
    output logic             FIFOEMPTY,
    output logic             BOEQ3,
    output logic [1:0]       BO,
    output logic [PTR_W-1:0] NI_PTR,
    output logic [PTR_W-1:0] NO_PTR,
`ifdef FIFO_ERR_EN
    output logic             OVF,
    output logic             UNF,
`endif
    output logic [PTR_W:0]   FIFO_CNT
);

    localparam logic [PTR_W:0]   DEPTH_CNT = {1'b1, {PTR_W{1'b0}}};
    localparam logic [PTR_W:0]   CNT_ONE   = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ZERO  = '0;
    localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [PTR_W:0]   cnt_reg, cnt_next;
    logic [PTR_W-1:0] ni_reg, ni_next;
    logic [PTR_W-1:0] no_reg, no_next;
    logic [1:0]       bo_reg, bo_next;
    logic             full_reg, full_next;
    logic             empty_reg, empty_next;
    logic             ovf_set, unf_set;

    // Next-state for counter, pointers, byte offset and flags; flush wins
    always_comb begin
        cnt_next   = cnt_reg;
        ni_next    = ni_reg;
        no_next    = no_reg;
        bo_next    = bo_reg;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;

        if (FIFO_CLR) begin
            cnt_next = CNT_ZERO;
            ni_next  = '0;
            no_next  = '0;
            bo_next  = 2'b00;
        end else begin
            // Simultaneous fill and drain cancel; illegal requests are dropped
            case ({INCFIFO, DECFIFO})
                2'b10: begin
                    if (cnt_reg != DEPTH_CNT) cnt_next = cnt_reg + CNT_ONE;
                    else                      ovf_set  = 1'b1;
                end
                2'b01: begin
                    if (cnt_reg != CNT_ZERO) cnt_next = cnt_reg - CNT_ONE;
                    else                     unf_set  = 1'b1;
                end
                default: cnt_next = cnt_reg;
            endcase

            // Pointers wrap naturally at DEPTH-1 and never look at the count
            if (INCNI) ni_next = ni_reg + PTR_ONE;
            if (INCNO) no_next = no_reg + PTR_ONE;

            // Address load beats increment when both arrive together
            if (BO_LD)      bo_next = BO_D;
            else if (INCBO) bo_next = bo_reg + 2'b01;
        end

        full_next  = (cnt_next == DEPTH_CNT);
        empty_next = (cnt_next == CNT_ZERO);
    end

    // State registers with asynchronous reset to an empty, zeroed FIFO
    always_ff @(posedge CPUCLK or posedge RESET) begin
        if (RESET) begin
            cnt_reg   <= CNT_ZERO;
            ni_reg    <= '0;
            no_reg    <= '0;
            bo_reg    <= 2'b00;
            full_reg  <= 1'b0;
            empty_reg <= 1'b1;
        end else begin
            cnt_reg   <= cnt_next;
            ni_reg    <= ni_next;
            no_reg    <= no_next;
            bo_reg    <= bo_next;
            full_reg  <= full_next;
            empty_reg <= empty_next;
        end
    end

`ifdef FIFO_ERR_EN
    logic ovf_reg, unf_reg;

    // Sticky error flags; only reset or a flush clears them
    always_ff @(posedge CPUCLK or posedge RESET) begin
        if (RESET) begin
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else if (FIFO_CLR) begin
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            ovf_reg <= ovf_reg | ovf_set;
            unf_reg <= unf_reg | unf_set;
        end
    end

    assign OVF = ovf_reg;
    assign UNF = unf_reg;
`else
    logic unused_err;
    assign unused_err = ovf_set | unf_set;
`endif

    assign FIFO_CNT  = cnt_reg;
    assign NI_PTR    = ni_reg;
    assign NO_PTR    = no_reg;
    assign BO        = bo_reg;
    assign FIFOFULL  = full_reg;
    assign FIFOEMPTY = empty_reg;
    assign BOEQ3     = (bo_reg == 2'b11);

endmodule

// File: tb/tb_sdmac_fifo_ctrl.sv
// Testbench for sdmac_fifo_ctrl: table of stimulus/expected records pushed
// through a scoreboard queue, plus hand-written reset sequences.
module tb_sdmac_fifo_ctrl;

    logic       CPUCLK = 1'b0;
    logic       RESET;
    logic       FIFO_CLR, INCFIFO, DECFIFO, INCNI, INCNO, INCBO, BO_LD;
    logic [1:0] BO_D;
    logic       FIFOFULL, FIFOEMPTY, BOEQ3;
    logic [1:0] BO;
    logic [2:0] NI_PTR, NO_PTR;
    logic [3:0] FIFO_CNT;
    logic [1:0] act_err;

`ifdef FIFO_ERR_EN
    logic OVF, UNF;
    assign act_err = {OVF, UNF};
`else
    assign act_err = 2'b00;
`endif

    sdmac_fifo_ctrl #(.PTR_W(3)) dut (
        .CPUCLK    (CPUCLK),
        .RESET     (RESET),
        .FIFO_CLR  (FIFO_CLR),
        .INCFIFO   (INCFIFO),
        .DECFIFO   (DECFIFO),
        .INCNI     (INCNI),
        .INCNO     (INCNO),
        .INCBO     (INCBO),
        .BO_LD     (BO_LD),
        .BO_D      (BO_D),
        .FIFOFULL  (FIFOFULL),
        .FIFOEMPTY (FIFOEMPTY),
        .BOEQ3     (BOEQ3),
        .BO        (BO),
        .NI_PTR    (NI_PTR),
        .NO_PTR    (NO_PTR),
`ifdef FIFO_ERR_EN
        .OVF       (OVF),
        .UNF       (UNF),
`endif
        .FIFO_CNT  (FIFO_CNT)
    );

    always #5 CPUCLK = ~CPUCLK;

    typedef struct {
        string      name;
        logic       clr, incf, decf, incni, incno, incbo, bold;
        logic [1:0] bod;
        logic [3:0] cnt;
        logic [2:0] ni, no;
        logic [1:0] bo;
        logic       ovf, unf;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input string name,
                       input logic clr, input logic incf, input logic decf,
                       input logic incni, input logic incno, input logic incbo,
                       input logic bold, input logic [1:0] bod,
                       input logic [3:0] cnt, input logic [2:0] ni,
                       input logic [2:0] no, input logic [1:0] bo,
                       input logic ovf, input logic unf);
        vec_t v;
        v.name = name; v.clr = clr; v.incf = incf; v.decf = decf;
        v.incni = incni; v.incno = incno; v.incbo = incbo; v.bold = bold;
        v.bod = bod; v.cnt = cnt; v.ni = ni; v.no = no; v.bo = bo;
        v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endtask

    // Expected output word: counter, pointers, offset, the flags implied by
    // them, then the error bits (always zero when the feature is absent).
    function automatic logic [16:0] exp_word(input logic [3:0] cnt,
                                             input logic [2:0] ni,
                                             input logic [2:0] no,
                                             input logic [1:0] bo,
                                             input logic ovf, input logic unf);
        logic [1:0] err;
`ifdef FIFO_ERR_EN
        err = {ovf, unf};
`else
        err = 2'b00 & {ovf, unf};
`endif
        return {cnt, ni, no, bo, (cnt == 4'd8), (cnt == 4'd0), (bo == 2'b11), err};
    endfunction

    task automatic check(input string name, input logic [16:0] exp);
        logic [16:0] act;
        act = {FIFO_CNT, NI_PTR, NO_PTR, BO, FIFOFULL, FIFOEMPTY, BOEQ3, act_err};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got cnt=%0d ni=%0d no=%0d bo=%0d full=%b empty=%b boeq3=%b err=%b, want cnt=%0d ni=%0d no=%0d bo=%0d full=%b empty=%b boeq3=%b err=%b",
                     name, act[16:13], act[12:10], act[9:7], act[6:5], act[4], act[3], act[2], act[1:0],
                     exp[16:13], exp[12:10], exp[9:7], exp[6:5], exp[4], exp[3], exp[2], exp[1:0]);
        end else begin
            $display("ok   %s: cnt=%0d ni=%0d no=%0d bo=%0d full=%b empty=%b boeq3=%b err=%b",
                     name, act[16:13], act[12:10], act[9:7], act[6:5], act[4], act[3], act[2], act[1:0]);
        end
    endtask

    task automatic drive(input logic clr, input logic incf, input logic decf,
                         input logic incni, input logic incno, input logic incbo,
                         input logic bold, input logic [1:0] bod);
        FIFO_CLR = clr; INCFIFO = incf; DECFIFO = decf; INCNI = incni;
        INCNO = incno; INCBO = incbo; BO_LD = bold; BO_D = bod;
    endtask

    initial begin
        vec_t e;

        // ---- stimulus table ----
        for (int i = 1; i <= 8; i++)
            add("t1_fill", 0,1,0,1,0,0,0,2'd0, 4'(i), 3'(i), 3'd0, 2'd0, 0,0);
        add("t2_ovf",  0,1,0,0,0,0,0,2'd0, 4'd8, 3'd0, 3'd0, 2'd0, 1,0);
        add("t2_dec",  0,0,1,0,1,0,0,2'd0, 4'd7, 3'd0, 3'd1, 2'd0, 1,0);
        add("t2_clr",  1,0,0,0,0,0,0,2'd0, 4'd0, 3'd0, 3'd0, 2'd0, 0,0);
        for (int i = 1; i <= 4; i++)
            add("t3_inc", 0,1,0,0,0,0,0,2'd0, 4'(i), 3'd0, 3'd0, 2'd0, 0,0);
        for (int i = 0; i < 3; i++)
            add("t3_both", 0,1,1,0,0,0,0,2'd0, 4'd4, 3'd0, 3'd0, 2'd0, 0,0);
        for (int i = 3; i >= 0; i--)
            add("t3_dec", 0,0,1,0,0,0,0,2'd0, 4'(i), 3'd0, 3'd0, 2'd0, 0,0);
        add("t3_unf",  0,0,1,0,0,0,0,2'd0, 4'd0, 3'd0, 3'd0, 2'd0, 0,1);
        add("t3_inc1", 0,1,0,0,0,0,0,2'd0, 4'd1, 3'd0, 3'd0, 2'd0, 0,1);
        add("t3_dec1", 0,0,1,0,0,0,0,2'd0, 4'd0, 3'd0, 3'd0, 2'd0, 0,1);
        add("t4_ld2",  0,0,0,0,0,0,1,2'd2, 4'd0, 3'd0, 3'd0, 2'd2, 0,1);
        add("t4_inc3", 0,0,0,0,0,1,0,2'd0, 4'd0, 3'd0, 3'd0, 2'd3, 0,1);
        add("t4_wrap", 0,0,0,0,0,1,0,2'd0, 4'd0, 3'd0, 3'd0, 2'd0, 0,1);
        add("t4_ldpri",0,0,0,0,0,1,1,2'd1, 4'd0, 3'd0, 3'd0, 2'd1, 0,1);
        add("t4_ld3",  0,0,0,0,0,0,1,2'd3, 4'd0, 3'd0, 3'd0, 2'd3, 0,1);
        for (int i = 1; i <= 5; i++)
            add("t5_fill", 0,1,0,1,0,0,0,2'd0, 4'(i), 3'(i), 3'd0, 2'd3, 0,1);
        for (int i = 1; i <= 2; i++)
            add("t5_no", 0,0,0,0,1,0,0,2'd0, 4'd5, 3'd5, 3'(i), 2'd3, 0,1);
        add("t5_clr",  1,1,0,1,1,1,0,2'd0, 4'd0, 3'd0, 3'd0, 2'd0, 0,0);
        for (int i = 1; i <= 8; i++)
            add("t5_nowrap", 0,0,0,0,1,0,0,2'd0, 4'd0, 3'd0, 3'(i), 2'd0, 0,0);

        // ---- reset state, checked before any clock edge ----
        drive(0,0,0,0,0,0,0,2'd0);
        RESET = 1'b1;
        #2;
        check("reset_init", exp_word(4'd0, 3'd0, 3'd0, 2'd0, 0, 0));
        @(negedge CPUCLK);
        RESET = 1'b0;

        // ---- table run through the scoreboard ----
        foreach (vecs[k]) begin
            drive(vecs[k].clr, vecs[k].incf, vecs[k].decf, vecs[k].incni,
                  vecs[k].incno, vecs[k].incbo, vecs[k].bold, vecs[k].bod);
            sb_q.push_back(vecs[k]);
            @(posedge CPUCLK);
            #1;
            e = sb_q.pop_front();
            check(e.name, exp_word(e.cnt, e.ni, e.no, e.bo, e.ovf, e.unf));
            @(negedge CPUCLK);
        end

        // ---- asynchronous reset mid-fill ----
        drive(0,1,0,1,0,0,0,2'd0);
        repeat (3) @(posedge CPUCLK);
        #1;
        check("t6_fill3", exp_word(4'd3, 3'd3, 3'd0, 2'd0, 0, 0));
        @(negedge CPUCLK);
        drive(0,0,0,0,0,0,0,2'd0);
        #1;
        RESET = 1'b1;
        #1;
        check("t6_async", exp_word(4'd0, 3'd0, 3'd0, 2'd0, 0, 0));
        @(negedge CPUCLK);
        RESET = 1'b0;
        drive(0,1,0,0,0,0,0,2'd0);
        @(posedge CPUCLK);
        #1;
        check("t6_resume", exp_word(4'd1, 3'd0, 3'd0, 2'd0, 0, 0));
        @(negedge CPUCLK);
        drive(0,0,0,0,0,0,0,2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

endmodule
